// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
//   fetch_state_t   : fetch sequencer states
//   PIPE_NOP_INSTR  : bubble encoding (sll $0,$0,0)
//   PIPE_EXC_VECTOR : exception entry address, shared with the exception logic
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PIPE_NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] PIPE_EXC_VECTOR = 32'h8000_0180;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with flush > stall > load priority.
//   clk, reset      : clock, synchronous active-low reset
//   flush           : slot becomes a bubble (valid=0, instr=NOP)
//   stall           : all fields hold
//   load            : capture instr_in / pc_in and mark valid
//   instr_in, pc_in : incoming word and its associated PC value
//   instr, pc, valid: registered slot contents
// With neither stall nor load the slot drains to a bubble. pc is left
// unchanged by bubbles so it still names the last real instruction.
module if_id_reg #(
  parameter int          W   = 32,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         stall,
  input  logic         load,
  input  logic [W-1:0] instr_in,
  input  logic [31:0]  pc_in,
  output logic [W-1:0] instr,
  output logic [31:0]  pc,
  output logic         valid
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr <= NOP;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (stall) begin
      instr <= instr;
      pc    <= pc;
      valid <= valid;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end else begin
      instr <= NOP;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and one-entry skid buffer.
//   clk, reset        : clock, synchronous active-low reset
//   imem_req/addr     : fetch request to instruction memory
//   imem_ready/rdata  : accept strobe and returned word
//   stall_d, flush_d  : IF/ID hold / invalidate from decode
//   redirect_d/_pc_d  : taken branch or jump and its target
//   exc_d             : exception raised in decode
//   instr_d, pcplus4_d, valid_d : IF/ID slot
//   epc               : address of the excepting instruction
//   state             : internal fetch_state_t, visible for debug probes
//
// Handshake: a fetch transfers in the cycle where imem_req and imem_ready
// are both 1; imem_rdata is valid in that same cycle. While imem_req=1 and
// imem_ready=0, imem_addr is held stable and imem_req stays asserted.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = PIPE_EXC_VECTOR,
  parameter logic [31:0] NOP_INSTR  = PIPE_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect_d,
  input  logic [31:0] redirect_pc_d,
  input  logic        exc_d,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic [31:0] epc
);

  fetch_state_t state, state_nx;
  logic [31:0]  req_addr, req_addr_nx;
  logic [31:0]  drop_tgt, drop_tgt_nx;
  logic [31:0]  skid_word, skid_word_nx;

  logic         redir;
  logic [31:0]  tgt;
  logic         accept;
  logic         word_avail;
  logic [31:0]  word;

  assign redir  = exc_d | redirect_d;
  assign tgt    = exc_d ? EXC_VECTOR : redirect_pc_d;
  // A flush empties the slot, so decode can take a word even while stalled.
  assign accept = ~stall_d | flush_d;

  // The address register always names the word in flight (or parked in the
  // skid buffer while in HOLD), so it drives the bus directly.
  assign imem_addr = req_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      req_addr  <= RESET_PC;
      drop_tgt  <= RESET_PC;
      skid_word <= NOP_INSTR;
      epc       <= '0;
    end else begin
      state     <= state_nx;
      req_addr  <= req_addr_nx;
      drop_tgt  <= drop_tgt_nx;
      skid_word <= skid_word_nx;
      if (exc_d) epc <= pcplus4_d - 32'd4;
    end
  end

  always_comb begin
    state_nx     = state;
    req_addr_nx  = req_addr;
    drop_tgt_nx  = drop_tgt;
    skid_word_nx = skid_word;
    imem_req     = 1'b0;
    word_avail   = 1'b0;
    word         = imem_rdata;
    case (state)
      IDLE: begin
        state_nx = BUSY;
        if (redir) req_addr_nx = tgt;
      end
      BUSY: begin
        imem_req = 1'b1;
        if (redir) begin
          if (imem_ready) begin
            req_addr_nx = tgt;
          end else begin
            // Request cannot be withdrawn; remember where to go once it lands.
            drop_tgt_nx = tgt;
            state_nx    = DROP;
          end
        end else if (imem_ready) begin
          if (accept) begin
            word_avail  = 1'b1;
            req_addr_nx = req_addr + 32'd4;
          end else begin
            skid_word_nx = imem_rdata;
            state_nx     = HOLD;
          end
        end
      end
      DROP: begin
        imem_req = 1'b1;
        if (redir) drop_tgt_nx = tgt;
        if (imem_ready) begin
          // A redirect in the landing cycle is the latest one and wins.
          req_addr_nx = redir ? tgt : drop_tgt;
          state_nx    = BUSY;
        end
      end
      HOLD: begin
        if (redir) begin
          req_addr_nx = tgt;
          state_nx    = BUSY;
        end else if (accept) begin
          word_avail  = 1'b1;
          word        = skid_word;
          req_addr_nx = req_addr + 32'd4;
          state_nx    = BUSY;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // In both load paths req_addr is the address of the delivered word.
  if_id_reg #(
    .W   (32),
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush_d),
    .stall    (stall_d),
    .load     (word_avail),
    .instr_in (word),
    .pc_in    (req_addr + 32'd4),
    .instr    (instr_d),
    .pc       (pcplus4_d),
    .valid    (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_d, flush_d, redirect_d, exc_d;
  logic [31:0] redirect_pc_d;
  logic [31:0] instr_d, pcplus4_d, epc;
  logic        valid_d;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .redirect_d    (redirect_d),
    .redirect_pc_d (redirect_pc_d),
    .exc_d         (exc_d),
    .instr_d       (instr_d),
    .pcplus4_d     (pcplus4_d),
    .valid_d       (valid_d),
    .epc           (epc)
  );

  // Memory contents: word at address a is a ^ 0xCAFE_0000.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // ---------------- reference model ----------------
  // Fetch stream: one pending address, an optional squashed request with a
  // replacement target, and a parked-word queue of at most one entry.
  bit          m_started;
  logic [31:0] m_addr;
  bit          m_squash;
  logic [31:0] m_tgt;
  logic [31:0] m_park_q[$];
  logic [31:0] e_instr, e_pc4, e_epc;
  bit          e_valid;

  function automatic bit exp_req();
    return m_started && (m_park_q.size() == 0);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_started = 0;
      m_addr    = 32'h0;
      m_squash  = 0;
      m_tgt     = 32'h0;
      m_park_q.delete();
      e_instr   = 32'h0;
      e_pc4     = 32'h0;
      e_valid   = 0;
      e_epc     = 32'h0;
    end else begin
      bit          redir, accept, got;
      logic [31:0] tg, w, wa;
      redir  = exc_d || redirect_d;
      tg     = exc_d ? 32'h8000_0180 : redirect_pc_d;
      accept = !stall_d || flush_d;
      got    = 0;
      w      = 32'h0;
      wa     = 32'h0;
      if (exc_d) e_epc = e_pc4 - 32'd4;
      if (!m_started) begin
        m_started = 1;
        if (redir) m_addr = tg;
      end else if (m_park_q.size() != 0) begin
        if (redir) begin
          m_park_q.delete();
          m_addr = tg;
        end else if (accept) begin
          got = 1; w = m_park_q.pop_front(); wa = m_addr;
          m_addr = m_addr + 32'd4;
        end
      end else if (m_squash) begin
        if (redir) m_tgt = tg;
        if (imem_ready) begin
          m_addr   = m_tgt;
          m_squash = 0;
        end
      end else if (redir) begin
        if (imem_ready) m_addr = tg;
        else begin m_squash = 1; m_tgt = tg; end
      end else if (imem_ready) begin
        if (accept) begin
          got = 1; w = mem_word(m_addr); wa = m_addr;
          m_addr = m_addr + 32'd4;
        end else m_park_q.push_back(mem_word(m_addr));
      end
      if (flush_d) begin
        e_valid = 0; e_instr = 32'h0;
      end else if (stall_d) begin
        // slot holds
      end else if (got) begin
        e_valid = 1; e_instr = w; e_pc4 = wa + 32'd4;
      end else begin
        e_valid = 0; e_instr = 32'h0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model imem_req",  {31'b0, imem_req}, {31'b0, exp_req()});
      chk("model imem_addr", imem_addr, m_addr);
      chk("model instr_d",   instr_d, e_instr);
      chk("model pcplus4_d", pcplus4_d, e_pc4);
      chk("model valid_d",   {31'b0, valid_d}, {31'b0, e_valid});
      chk("model epc",       epc, e_epc);
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge: apply inputs, advance through one rising edge,
  // return at the next negedge.
  task automatic step(input logic rdy, input logic stl, input logic fl,
                      input logic rd, input logic [31:0] tg, input logic ex);
    imem_ready    = rdy;
    stall_d       = stl;
    flush_d       = fl;
    redirect_d    = rd;
    redirect_pc_d = tg;
    exc_d         = ex;
    @(negedge clk);
  endtask

  task automatic go(input logic rdy);
    step(rdy, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic redirect(input logic rdy, input logic [31:0] tg);
    step(rdy, 1'b0, 1'b1, 1'b1, tg, 1'b0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst imem_req",  {31'b0, imem_req}, 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst instr_d",   instr_d, 32'h0);
    chk("rst pcplus4_d", pcplus4_d, 32'h0);
    chk("rst valid_d",   {31'b0, valid_d}, 32'h0);
    chk("rst epc",       epc, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    imem_ready = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    redirect_d = 1'b0; redirect_pc_d = 32'h0; exc_d = 1'b0;
    @(negedge clk);
    go(1'b0);
    check_en = 1'b1;
    go(1'b0);
    chk_reset_outputs();

    // Start-up: one idle cycle, then zero-wait fetch at 0x0.
    reset = 1'b1;
    go(1'b1);
    chk("start req",  {31'b0, imem_req}, 32'h1);
    chk("start addr", imem_addr, 32'h0);
    go(1'b1);
    chk("zw instr@0", instr_d, 32'hCAFE_0000);
    chk("zw valid",   {31'b0, valid_d}, 32'h1);
    chk("zw addr 4",  imem_addr, 32'h4);

    // Three-cycle latency at 0x4.
    go(1'b0);
    chk("wait addr",  imem_addr, 32'h4);
    chk("wait valid", {31'b0, valid_d}, 32'h0);
    go(1'b0);
    chk("wait addr2", imem_addr, 32'h4);
    go(1'b1);
    chk("lat instr@4", instr_d, 32'hCAFE_0004);
    chk("lat pc4",     pcplus4_d, 32'h8);
    go(1'b1);
    chk("zw instr@8",  instr_d, 32'hCAFE_0008);

    // Stall while word@0xC returns: parked, no new request.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("park req",   {31'b0, imem_req}, 32'h0);
    chk("park hold",  instr_d, 32'hCAFE_0008);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("park req2",  {31'b0, imem_req}, 32'h0);
    go(1'b0);
    chk("unpark instr", instr_d, 32'hCAFE_000C);
    chk("unpark pc4",   pcplus4_d, 32'h10);
    chk("unpark addr",  imem_addr, 32'h10);
    for (int i = 0; i < 4; i++) go(1'b1);
    chk("seq instr@1C", instr_d, 32'hCAFE_001C);

    // Redirect while 0x20 is outstanding.
    go(1'b0);
    redirect(1'b0, 32'h100);
    chk("drop req",  {31'b0, imem_req}, 32'h1);
    chk("drop addr", imem_addr, 32'h20);
    go(1'b1);
    chk("drop discard valid", {31'b0, valid_d}, 32'h0);
    chk("drop new addr",      imem_addr, 32'h100);
    go(1'b1);
    chk("tgt instr@100", instr_d, 32'hCAFE_0100);

    // Exception with pcplus4_d = 0x44.
    redirect(1'b1, 32'h40);
    go(1'b1);
    chk("pre-exc pc4", pcplus4_d, 32'h44);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    chk("exc epc", epc, 32'h40);
    go(1'b1);
    chk("exc vector addr", imem_addr, 32'h8000_0180);
    go(1'b1);
    chk("vec instr", instr_d, 32'h4AFE_0180);

    // Address wrap.
    redirect(1'b1, 32'hFFFF_FFFC);
    go(1'b1);
    chk("wrap instr", instr_d, 32'h3501_FFFC);
    chk("wrap pc4",   pcplus4_d, 32'h0);
    chk("wrap addr",  imem_addr, 32'h0);

    // Redirect out of the skid buffer, then two redirects during DROP.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    redirect(1'b0, 32'h300);
    chk("hold redir addr", imem_addr, 32'h300);
    redirect(1'b0, 32'h400);
    redirect(1'b0, 32'h500);
    go(1'b1);
    chk("latest wins", imem_addr, 32'h500);

    // Reset in the middle of a wait.
    go(1'b0);
    reset = 1'b0;
    go(1'b0);
    chk_reset_outputs();
    reset = 1'b1;
    go(1'b1);
    go(1'b1);
    chk("restart instr@0", instr_d, 32'hCAFE_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register. It sits directly upstream of the main decoder and presents the fetched instruction word, its PC+4 and a valid bit, from which the decoder takes op (instr_d[31:26]) and funct (instr_d[5:0]). It issues requests to instruction memory over a req/ready handshake and accepts redirects from decode (branch, jump, jr/jalr) and exceptions (undefined instruction). It also contains a one-entry skid buffer so that no returned word is lost while decode is stalled.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
EXC_VECTOR, 32'h8000_0180, fetch target on exception
NOP_INSTR, 32'h0000_0000, word driven on instr_d when the slot is invalid (sll $0,$0,0)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
imem_req  out  1  request valid
imem_addr  out  32  request address; held stable while imem_req=1 and imem_ready=0
imem_ready  in  1  request accepted and imem_rdata valid in the same cycle
imem_rdata  in  32  returned instruction word
stall_d  in  1  decode cannot accept a new instruction; IF/ID holds
flush_d  in  1  invalidate IF/ID
redirect_d  in  1  taken branch or jump
redirect_pc_d  in  32  target address for a redirect
exc_d  in  1  exception raised in decode
instr_d  out  32  IF/ID instruction
pcplus4_d  out  32  IF/ID PC+4
valid_d  out  1  IF/ID slot holds a real instruction
epc  out  32  address of the instruction that raised the exception

Behaviour:
- Reset (reset==0 at a clock edge):
  - instr_d=NOP_INSTR, pcplus4_d=0, valid_d=0, epc=0.
  - imem_req=0, imem_addr=RESET_PC, skid buffer empty, state=IDLE.
  - Reset asserted mid-transaction abandons the outstanding request. The memory side must tolerate this.
- State machine:
  - IDLE: imem_req=0. Next state BUSY, with req_addr equal to the pending target (RESET_PC after reset).
  - BUSY: imem_req=1, imem_addr=req_addr.
    - On ready with no redirect or exception: the word goes to IF/ID if decode accepts, otherwise to the skid buffer.
    - If the word went to IF/ID: req_addr+=4 and stay in BUSY (back-to-back issue).
    - If the word went to the skid buffer: go to HOLD.
  - DROP: imem_req=1 and the address is held. A redirect arrived while the request was outstanding. On ready, discard the data, set req_addr to the stored target and go to BUSY.
  - HOLD: imem_req=0. When decode accepts, move the skid entry to IF/ID, set req_addr = held addr+4 and go to BUSY.
- Decode accepts when stall_d==0, or when flush_d==1 (the slot is refilled invalid).
- Redirect priority: exc_d > redirect_d > sequential.
  - Target is EXC_VECTOR when exc_d=1, else redirect_pc_d.
  - On exc_d=1: epc = pcplus4_d-4.
  - BUSY without ready: go to DROP and store the target. A later redirect while in DROP overwrites the target (latest wins).
  - BUSY with ready: discard the data, set req_addr=target and stay in BUSY.
  - HOLD: clear the skid buffer, set req_addr=target and go to BUSY.
  - IDLE: the target replaces the pending address.
- IF/ID update priority: flush_d > stall_d > load.
  - flush_d: valid_d=0, instr_d=NOP_INSTR.
  - stall_d: all IF/ID registers hold.
  - load: valid_d=1, instr_d=word, pcplus4_d=addr+4.
  - Any cycle with no word available and no stall: valid_d=0, instr_d=NOP_INSTR.
- Redirect and exception imply the caller also asserts flush_d. The block does not self-flush.
- Latency and throughput:
  - Zero-wait memory: the word at A appears on instr_d one cycle after the req/ready cycle.
  - Sustained rate is 1 instruction per cycle.
- Arithmetic: addr+4 is mod 2^32 (0xFFFF_FFFC wraps to 0). Bits [1:0] of all addresses pass through unchecked.
- The skid buffer is one entry. A new request is never issued while it is full, so overflow is impossible.

Decomposition:
- Shared package (pipeline_pkg): fetch_state_t enum {IDLE, BUSY, DROP, HOLD}, the NOP encoding, and the exception vector constant shared with the exception logic.
- One sub-module, if_id_reg: the IF/ID register with flush/stall/load priority, reusable for the other pipeline registers.

Test Plan:
- Reset then zero-wait memory (ready tied 1): addresses 0x0, 0x4, 0x8 on consecutive cycles; instr_d sequence follows one cycle later; valid_d=1 from cycle 2.
- Memory with 3-cycle latency at 0x4: imem_addr is held at 0x4 for 3 cycles; valid_d=0 during the wait; then instr_d = word@0x4 and pcplus4_d=0x8.
- stall_d=1 for 2 cycles while ready returns word@0xC: the word is parked in the skid buffer and imem_req=0. When the stall releases, instr_d=word@0xC and the next request goes to 0x10. No word is lost or duplicated.
- redirect_d=1, target 0x100, while the request to 0x20 is outstanding and not ready: state is DROP; word@0x20 is never placed on instr_d; the next imem_addr is 0x100.
- exc_d and redirect_d asserted together with pcplus4_d=0x44: next fetch goes to 0x8000_0180 and epc=0x40.
- Fetch at 0xFFFF_FFFC: the following request address is 0x0000_0000. reset=0 mid-wait returns all outputs to their reset values on the next edge.
